// File: rtl/vga_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_clk_pkg
//  Purpose  : Shared types and helpers for the display clock/reset blocks:
//             supervisor state encoding plus a width helper for counters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_clk_pkg;

   // Supervisor state encoding
   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      FILTER    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } sup_state_t;

   // Bits needed to hold the values 0 .. value-1 (minimum 1 bit)
   function automatic int width_for(input int value);
      int w;
      w = 1;
      while ((w < 31) && ((64'd1 << w) < 64'(value)))
         w = w + 1;
      return w;
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_2ff
//  Purpose  : Two-flop synchroniser for asynchronous level inputs; both flops
//             clear to 0 on the asynchronous active-low reset.
//  Ports    : clk    in   sampling clock
//             rst_n  in   asynchronous active-low reset
//             d      in   WIDTH asynchronous input bits
//             q      out  WIDTH synchronised bits (2-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pll_lock_supervisor
//  Purpose  : Drives the display PLL reset, filters its locked flag, retries
//             on lock timeout and releases downstream resets in staggered
//             order once lock is stable. Runs on the 50 MHz reference clock.
//  Ports    : refclk          in   reference clock (only clock)
//             rst_n           in   asynchronous active-low reset
//             pll_locked_in   in   raw PLL locked flag (asynchronous)
//             sw_restart      in   1-cycle pulse, full restart from any state
//             pll_rst_out     out  active-high PLL reset
//             chan_rst_n_out  out  per-channel active-low resets, bit 0 first
//             all_ready       out  high only in RUN
//             fault           out  high only in FAULT
//             retry_count     out  failed lock attempts since RUN/sw_restart
//  Revision : 1.0  initial release
// ============================================================================
module vga_pll_lock_supervisor
   import vga_clk_pkg::*;
#(
   parameter  int NUM_CHANNELS          = 3,
   parameter  int PLL_RST_PULSE_CYCLES  = 16,
   parameter  int LOCK_FILTER_CYCLES    = 1024,
   parameter  int RELOCK_TIMEOUT_CYCLES = 50000,
   parameter  int STAGGER_CYCLES        = 8,
   parameter  int MAX_RETRIES           = 3,
   localparam int RETRY_W               = width_for(MAX_RETRIES + 1)
) (
   input  logic                    refclk,
   input  logic                    rst_n,
   input  logic                    pll_locked_in,
   input  logic                    sw_restart,
   output logic                    pll_rst_out,
   output logic [NUM_CHANNELS-1:0] chan_rst_n_out,
   output logic                    all_ready,
   output logic                    fault,
   output logic [RETRY_W-1:0]      retry_count
);

   localparam int CNT_MAX = max_of(max_of(PLL_RST_PULSE_CYCLES, LOCK_FILTER_CYCLES),
                                   max_of(RELOCK_TIMEOUT_CYCLES, STAGGER_CYCLES));
   // One extra value of headroom: the reset load below uses the full pulse count
   localparam int CNT_W   = width_for(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PLL_RST_PULSE_CYCLES - 1);
   // Out of rst_n the first running edge is consumed by the count, so the
   // PLL still sees PULSE cycles of reset on a live clock after release.
   localparam logic [CNT_W-1:0] PULSE_RESET  = CNT_W'(PLL_RST_PULSE_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(RELOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILTER_LOAD  = CNT_W'(LOCK_FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

   localparam logic [RETRY_W-1:0]      RETRY_ONE   = RETRY_W'(1);
   localparam logic [RETRY_W-1:0]      RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
   localparam logic [NUM_CHANNELS-1:0] CHAN_FIRST  = NUM_CHANNELS'(1);

   sup_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic               lock_s;
   logic [RETRY_W-1:0] retry_inc;

   vga_sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked_in),
      .q     (lock_s)
   );

   assign retry_inc = retry_count + RETRY_ONE;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= PLL_RST;
         cnt            <= PULSE_RESET;
         pll_rst_out    <= 1'b1;
         chan_rst_n_out <= '0;
         all_ready      <= 1'b0;
         fault          <= 1'b0;
         retry_count    <= '0;
      end else if (sw_restart) begin
         // Highest priority: overrides any coincident timeout or lock loss
         state          <= PLL_RST;
         cnt            <= PULSE_LOAD;
         pll_rst_out    <= 1'b1;
         chan_rst_n_out <= '0;
         all_ready      <= 1'b0;
         fault          <= 1'b0;
         retry_count    <= '0;
      end else begin
         case (state)
            PLL_RST: begin
               if (cnt == '0) begin
                  state       <= WAIT_LOCK;
                  cnt         <= TIMEOUT_LOAD;
                  pll_rst_out <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= FILTER;
                  cnt   <= FILTER_LOAD;
               end else if (cnt == '0) begin
                  retry_count <= retry_inc;
                  pll_rst_out <= 1'b1;
                  if (retry_inc == RETRY_LIMIT) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state <= PLL_RST;
                     cnt   <= PULSE_LOAD;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            FILTER: begin
               if (!lock_s) begin
                  // A single dropout restarts the whole wait, not just the filter
                  state <= WAIT_LOCK;
                  cnt   <= TIMEOUT_LOAD;
               end else if (cnt == '0) begin
                  state          <= RELEASE;
                  cnt            <= STAGGER_LOAD;
                  chan_rst_n_out <= CHAN_FIRST;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            RELEASE: begin
               if (!lock_s) begin
                  state          <= PLL_RST;
                  cnt            <= PULSE_LOAD;
                  pll_rst_out    <= 1'b1;
                  chan_rst_n_out <= '0;
                  all_ready      <= 1'b0;
               end else if (&chan_rst_n_out) begin
                  state       <= RUN;
                  all_ready   <= 1'b1;
                  retry_count <= '0;
               end else if (cnt == '0) begin
                  // Shift a one in from the bottom: channels release in bit order
                  chan_rst_n_out <= (chan_rst_n_out << 1) | CHAN_FIRST;
                  cnt            <= STAGGER_LOAD;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            RUN: begin
               if (!lock_s) begin
                  state          <= PLL_RST;
                  cnt            <= PULSE_LOAD;
                  pll_rst_out    <= 1'b1;
                  chan_rst_n_out <= '0;
                  all_ready      <= 1'b0;
               end
            end

            FAULT: begin
               // Parked until sw_restart or rst_n; lock is ignored here
            end

            default: begin
               state          <= PLL_RST;
               cnt            <= PULSE_LOAD;
               pll_rst_out    <= 1'b1;
               chan_rst_n_out <= '0;
               all_ready      <= 1'b0;
               fault          <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pll_lock_supervisor
//  Purpose  : Self-checking bench for vga_pll_lock_supervisor. A mode/elapsed-
//             time reference model predicts every output each cycle; directed
//             scenarios plus a randomized lock/restart/reset phase drive it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pll_lock_supervisor;

   localparam int NCH   = 3;
   localparam int PULSE = 4;
   localparam int FILT  = 8;
   localparam int TMO   = 40;
   localparam int STAG  = 2;
   localparam int MAXR  = 2;
   localparam int RW    = 2;

   // Reference-model modes
   localparam int M_PLL   = 0;
   localparam int M_WAIT  = 1;
   localparam int M_FILT  = 2;
   localparam int M_REL   = 3;
   localparam int M_RUN   = 4;
   localparam int M_FAULT = 5;

   logic           refclk        = 1'b0;
   logic           rst_n         = 1'b0;
   logic           pll_locked_in = 1'b0;
   logic           sw_restart    = 1'b0;
   logic           pll_rst_out;
   logic [NCH-1:0] chan_rst_n_out;
   logic           all_ready;
   logic           fault;
   logic [RW-1:0]  retry_count;

   vga_pll_lock_supervisor #(
      .NUM_CHANNELS          (NCH),
      .PLL_RST_PULSE_CYCLES  (PULSE),
      .LOCK_FILTER_CYCLES    (FILT),
      .RELOCK_TIMEOUT_CYCLES (TMO),
      .STAGGER_CYCLES        (STAG),
      .MAX_RETRIES           (MAXR)
   ) dut (
      .refclk         (refclk),
      .rst_n          (rst_n),
      .pll_locked_in  (pll_locked_in),
      .sw_restart     (sw_restart),
      .pll_rst_out    (pll_rst_out),
      .chan_rst_n_out (chan_rst_n_out),
      .all_ready      (all_ready),
      .fault          (fault),
      .retry_count    (retry_count)
   );

   always #5 refclk = ~refclk;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_el = clock edges seen since entering the current mode (-1 under rst_n,
   // because the first running edge after reset is still part of the pulse).
   int m_mode  = M_PLL;
   int m_el    = -1;
   int m_retry = 0;
   bit p1      = 1'b0;
   bit p2      = 1'b0;

   function automatic void enter(input int mode);
      m_mode = mode;
      m_el   = 0;
   endfunction

   always @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_PLL; m_el = -1; m_retry = 0; p1 = 1'b0; p2 = 1'b0;
      end else begin : step
         bit ls;
         int n;
         ls = p2; p2 = p1; p1 = pll_locked_in;   // lock seen two edges late
         n = m_el + 1;
         m_el = n;
         if (sw_restart) begin
            enter(M_PLL);
            m_retry = 0;
         end else begin
            case (m_mode)
               M_PLL:  if (n == PULSE) enter(M_WAIT);
               M_WAIT: begin
                  if (ls) enter(M_FILT);
                  else if (n == TMO) begin
                     m_retry++;
                     enter((m_retry == MAXR) ? M_FAULT : M_PLL);
                  end
               end
               M_FILT: begin
                  if (!ls) enter(M_WAIT);
                  else if (n == FILT) enter(M_REL);
               end
               M_REL: begin
                  if (!ls) enter(M_PLL);
                  else if (n == (NCH - 1) * STAG + 1) begin
                     enter(M_RUN);
                     m_retry = 0;
                  end
               end
               M_RUN:  if (!ls) enter(M_PLL);
               default: ;
            endcase
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge refclk) begin
      if (chk_en) begin : cmp
         logic [NCH-1:0] ec;
         ec = '0;
         if (m_mode == M_RUN) ec = '1;
         else if (m_mode == M_REL)
            for (int i = 0; i < NCH; i++) ec[i] = (m_el >= i * STAG);
         check_eq("pll_rst_out", pll_rst_out, (m_mode == M_PLL) || (m_mode == M_FAULT));
         check_eq("chan_rst_n", chan_rst_n_out, ec);
         check_eq("all_ready", all_ready, m_mode == M_RUN);
         check_eq("fault", fault, m_mode == M_FAULT);
         check_eq("retry_count", retry_count, m_retry);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic pulse_restart();
      sw_restart = 1'b1;
      @(negedge refclk);
      sw_restart = 1'b0;
   endtask

   // Wait until the model reaches a mode (and elapsed count, el>=0) or give up
   task automatic wait_model(input int mode, input int el, input int budget, input string tag);
      int k;
      k = 0;
      while (!(m_mode == mode && (el < 0 || m_el == el)) && k < budget) begin
         @(negedge refclk);
         k++;
      end
      if (k >= budget) check_eq({tag, "_wait_expired"}, k, 0);
   endtask

   // Assert rst_n between edges and confirm outputs drop without a clock
   task automatic async_reset_check(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check_eq({tag, "_async_chan"}, chan_rst_n_out, 0);
      check_eq({tag, "_async_ready"}, all_ready, 0);
      check_eq({tag, "_async_pll"}, pll_rst_out, 1);
   endtask

   // Called on the negedge where rst_n was released, with the pin low
   task automatic bringup(input string pfx);
      int hi, tb0, tb1, tb2, tr;
      hi = 0; tb0 = -1; tb1 = -1; tb2 = -1; tr = -1;
      for (int c = 0; c < 120; c++) begin
         if (c == 10) pll_locked_in = 1'b1;
         @(negedge refclk);
         if (c < 8 && pll_rst_out) hi++;
         if (tb0 < 0 && chan_rst_n_out[0]) tb0 = c;
         if (tb1 < 0 && chan_rst_n_out[1]) tb1 = c;
         if (tb2 < 0 && chan_rst_n_out[2]) tb2 = c;
         if (tr  < 0 && all_ready)         tr  = c;
      end
      check_eq({pfx, "_pulse_len"}, hi, PULSE);
      check_eq({pfx, "_bit1_delay"}, tb1 - tb0, STAG);
      check_eq({pfx, "_bit2_delay"}, tb2 - tb0, 2 * STAG);
      check_eq({pfx, "_ready_delay"}, tr - tb0, 2 * STAG + 1);
      check_eq({pfx, "_retry"}, retry_count, 0);
   endtask

   initial begin : stim
      int hold;
      int k;

      // ---- Reset and scenario 1: clean bring-up ----
      cyc(1);
      chk_en = 1'b1;
      check_eq("reset_pll", pll_rst_out, 1);
      check_eq("reset_chan", chan_rst_n_out, 0);
      check_eq("reset_fault", fault, 0);
      cyc(2);
      rst_n = 1'b1;
      bringup("s1");

      // ---- Scenario 2: one-cycle glitch mid-filter ----
      pulse_restart();
      wait_model(M_FILT, 4, 60, "s2");
      pll_locked_in = 1'b0;
      cyc(1);
      pll_locked_in = 1'b1;
      cyc(3);
      check_eq("s2_no_release", chan_rst_n_out, 0);
      wait_model(M_RUN, -1, 80, "s2_run");
      cyc(1);
      check_eq("s2_ready", all_ready, 1);
      check_eq("s2_retry", retry_count, 0);

      // ---- Scenario 3: lock never comes ----
      pll_locked_in = 1'b0;
      pulse_restart();
      cyc(PULSE + TMO);
      check_eq("s3_retry1", retry_count, 1);
      check_eq("s3_pulse2", pll_rst_out, 1);
      cyc(PULSE);
      check_eq("s3_pulse2_end", pll_rst_out, 0);
      cyc(TMO);
      check_eq("s3_fault", fault, 1);
      check_eq("s3_retry2", retry_count, MAXR);
      check_eq("s3_pll_held", pll_rst_out, 1);
      pll_locked_in = 1'b1;              // ignored in FAULT
      cyc(10);
      check_eq("s3_fault_sticky", fault, 1);
      pll_locked_in = 1'b0;

      // ---- Scenario 5: restart from FAULT, then coincident with timeout ----
      pulse_restart();
      check_eq("s5a_fault", fault, 0);
      check_eq("s5a_retry", retry_count, 0);
      check_eq("s5a_pll", pll_rst_out, 1);
      wait_model(M_WAIT, TMO - 1, 80, "s5b");
      pulse_restart();
      check_eq("s5b_retry", retry_count, 0);
      check_eq("s5b_pll", pll_rst_out, 1);

      // ---- Scenario 4: lock loss in RUN ----
      pll_locked_in = 1'b1;
      wait_model(M_RUN, -1, 100, "s4");
      cyc(3);
      pll_locked_in = 1'b0;
      k = 0;
      while (chan_rst_n_out != '0 && k < 10) begin
         @(negedge refclk);
         k++;
      end
      check_eq("s4_loss_latency", k, 3);
      check_eq("s4_ready_together", all_ready, 0);
      hold = 0;
      for (int c = 0; c < 8; c++) begin
         if (pll_rst_out) hold++;
         @(negedge refclk);
      end
      check_eq("s4_new_pulse", hold, PULSE);

      // ---- Scenario 6: async reset mid-RELEASE ----
      pll_locked_in = 1'b1;
      pulse_restart();
      wait_model(M_REL, 0, 80, "s6");
      check_eq("s6_bit0_high", chan_rst_n_out[0], 1);
      async_reset_check("s6");
      pll_locked_in = 1'b0;
      @(negedge refclk);
      rst_n = 1'b1;
      bringup("s6");

      // ---- Randomized phase ----
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            pll_locked_in = ($urandom_range(0, 99) < 65);
            hold = pll_locked_in ? int'($urandom_range(5, 120)) : int'($urandom_range(1, 100));
         end else begin
            hold--;
         end
         sw_restart = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 999) == 0) begin
            sw_restart = 1'b0;
            async_reset_check("rnd");
            @(negedge refclk);
            rst_n = 1'b1;
            continue;
         end
         @(negedge refclk);
      end
      sw_restart = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
